// File: rtl/shift_reg_seq.sv
// Multi-mode shift register: one command shifts the register by a programmable
// number of positions, one position per clock, with a busy/done handshake.
module shift_reg_seq #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_data,
    input  logic               start,
    input  logic [2:0]         mode,
    input  logic [SHAMT_W-1:0] amount,
    input  logic               sin,
    output logic [WIDTH-1:0]   regout,
    output logic               sout,
    output logic               busy,
    output logic               done,
    output logic [1:0]         dbg_state
);

    // Handshake: load/start are sampled on a rising edge only while busy is low
    // (IDLE or DONE); busy stays high for exactly `amount` cycles, then done
    // pulses for one cycle. A start sampled during done chains with no gap.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [2:0] OP_SLL = 3'd0;
    localparam logic [2:0] OP_SRL = 3'd1;
    localparam logic [2:0] OP_ROL = 3'd2;
    localparam logic [2:0] OP_ROR = 3'd3;
    localparam logic [2:0] OP_SRA = 3'd4;

    state_t             state, state_d;
    logic [WIDTH-1:0]   r, r_d;
    logic [2:0]         op, op_d;
    logic [SHAMT_W-1:0] count, count_d;
    logic [WIDTH-1:0]   shifted;

    always_comb begin
        shifted = r;
        case (op)
            OP_SLL:  shifted = {r[WIDTH-2:0], sin};
            OP_SRL:  shifted = {sin, r[WIDTH-1:1]};
            OP_ROL:  shifted = {r[WIDTH-2:0], r[WIDTH-1]};
            OP_ROR:  shifted = {r[0], r[WIDTH-1:1]};
            OP_SRA:  shifted = {r[WIDTH-1], r[WIDTH-1:1]};
            default: shifted = r;  // reserved ops run the sequence but hold data
        endcase
    end

    always_comb begin
        state_d = state;
        r_d     = r;
        op_d    = op;
        count_d = count;
        case (state)
            IDLE, DONE: begin
                state_d = IDLE;
                if (load) begin
                    r_d = load_data;
                end else if (start) begin
                    op_d = mode;
                    if (amount == '0) begin
                        state_d = DONE;
                    end else begin
                        count_d = amount;
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                r_d     = shifted;
                count_d = count - SHAMT_W'(1);
                if (count == SHAMT_W'(1)) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            r     <= '0;
            op    <= OP_SRL;
            count <= '0;
        end else begin
            state <= state_d;
            r     <= r_d;
            op    <= op_d;
            count <= count_d;
        end
    end

    assign regout    = r;
    assign sout      = (op == OP_SLL || op == OP_ROL) ? r[WIDTH-1] : r[0];
    assign busy      = (state == SHIFT);
    assign done      = (state == DONE);
    assign dbg_state = state;

endmodule
